// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: buffers out-of-order results from two execution ways in a
// pID-indexed slot array and retires up to two per cycle, strictly in pID order.
module wb_commit_unit #(
   parameter int XLEN  = 64,
   parameter int PID_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             way0_valid_i,
   output logic             way0_ready_o,
   input  logic [PID_W-1:0] way0_pID_i,
   input  logic             way0_rdWen_i,
   input  logic [4:0]       way0_rdAddr_i,
   input  logic [XLEN-1:0]  way0_rdData_i,
   input  logic             way1_valid_i,
   output logic             way1_ready_o,
   input  logic [PID_W-1:0] way1_pID_i,
   input  logic             way1_rdWen_i,
   input  logic [4:0]       way1_rdAddr_i,
   input  logic [XLEN-1:0]  way1_rdData_i,
   input  logic             flush_i,
   output logic             way0_rdWriteEnable_o,
   output logic [4:0]       way0_rdAddr_o,
   output logic [XLEN-1:0]  way0_rdData_o,
   output logic [PID_W-1:0] way0_WBU_pID_o,
   output logic             way1_rdWriteEnable_o,
   output logic [4:0]       way1_rdAddr_o,
   output logic [XLEN-1:0]  way1_rdData_o,
   output logic [PID_W-1:0] way1_WBU_pID_o,
   input  logic             way0_ready_i,
   input  logic             way1_ready_i,
   output logic [63:0]      retire_cnt_o
);
   localparam int NSLOT = 2 ** PID_W;

   logic [NSLOT-1:0] slot_valid_q, slot_valid_d;
   logic [NSLOT-1:0] slot_wen_q, slot_wen_d;
   logic [4:0]       slot_addr_q [NSLOT];
   logic [4:0]       slot_addr_d [NSLOT];
   logic [XLEN-1:0]  slot_data_q [NSLOT];
   logic [XLEN-1:0]  slot_data_d [NSLOT];
   logic [PID_W-1:0] head_q, head_d, head_nxt;
   logic [63:0]      retire_cnt_q, retire_cnt_d;

   logic             w0_we_q, w0_we_d, w1_we_q, w1_we_d;
   logic [4:0]       w0_addr_q, w0_addr_d, w1_addr_q, w1_addr_d;
   logic [XLEN-1:0]  w0_data_q, w0_data_d, w1_data_q, w1_data_d;
   logic [PID_W-1:0] w0_pid_q, w0_pid_d, w1_pid_q, w1_pid_d;

   logic adv, c0, c1, acc0, acc1;

   // A slot is free to accept only when empty; nothing is accepted while flushing.
   assign way0_ready_o = ~slot_valid_q[way0_pID_i] & ~flush_i;
   assign way1_ready_o = ~slot_valid_q[way1_pID_i] & ~flush_i;
   assign acc0         = way0_valid_i & way0_ready_o;
   assign acc1         = way1_valid_i & way1_ready_o;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block can infer a latch.
      slot_valid_d = slot_valid_q;
      slot_wen_d   = slot_wen_q;
      slot_addr_d  = slot_addr_q;
      slot_data_d  = slot_data_q;
      head_d       = head_q;
      retire_cnt_d = retire_cnt_q;
      w0_we_d = w0_we_q;  w0_addr_d = w0_addr_q;  w0_data_d = w0_data_q;  w0_pid_d = w0_pid_q;
      w1_we_d = w1_we_q;  w1_addr_d = w1_addr_q;  w1_data_d = w1_data_q;  w1_pid_d = w1_pid_q;

      head_nxt = head_q + PID_W'(1);
      adv      = way0_ready_i & way1_ready_i;
      c0       = adv & ~flush_i & slot_valid_q[head_q];
      c1       = c0 & slot_valid_q[head_nxt];

      if (acc0) begin
         slot_valid_d[way0_pID_i] = 1'b1;
         slot_wen_d[way0_pID_i]   = way0_rdWen_i;
         slot_addr_d[way0_pID_i]  = way0_rdAddr_i;
         slot_data_d[way0_pID_i]  = way0_rdData_i;
      end
      if (acc1) begin
         slot_valid_d[way1_pID_i] = 1'b1;
         slot_wen_d[way1_pID_i]   = way1_rdWen_i;
         slot_addr_d[way1_pID_i]  = way1_rdAddr_i;
         slot_data_d[way1_pID_i]  = way1_rdData_i;
      end

      if (flush_i) begin
         slot_valid_d = '0;
         head_d       = '0;
         w0_we_d      = 1'b0;
         w1_we_d      = 1'b0;
      end else if (adv) begin
         w0_we_d = 1'b0;  w0_addr_d = '0;  w0_data_d = '0;  w0_pid_d = '0;
         w1_we_d = 1'b0;  w1_addr_d = '0;  w1_data_d = '0;  w1_pid_d = '0;
         if (c0) begin
            w0_we_d              = slot_wen_q[head_q] & (slot_addr_q[head_q] != 5'd0);
            w0_addr_d            = slot_addr_q[head_q];
            w0_data_d            = slot_data_q[head_q];
            w0_pid_d             = head_q;
            slot_valid_d[head_q] = 1'b0;
         end
         if (c1) begin
            w1_we_d                = slot_wen_q[head_nxt] & (slot_addr_q[head_nxt] != 5'd0);
            w1_addr_d              = slot_addr_q[head_nxt];
            w1_data_d              = slot_data_q[head_nxt];
            w1_pid_d               = head_nxt;
            slot_valid_d[head_nxt] = 1'b0;
         end
         // Two commits to the same rd in one cycle: only the younger result is written.
         if (c1 && w0_we_d && w1_we_d && (w0_addr_d == w1_addr_d)) begin
            w0_we_d = 1'b0;
         end
         head_d       = head_q + PID_W'(c0) + PID_W'(c1);
         retire_cnt_d = retire_cnt_q + 64'(c0) + 64'(c1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid_q <= '0;
         head_q       <= '0;
         retire_cnt_q <= '0;
         w0_we_q <= 1'b0;  w0_addr_q <= '0;  w0_data_q <= '0;  w0_pid_q <= '0;
         w1_we_q <= 1'b0;  w1_addr_q <= '0;  w1_data_q <= '0;  w1_pid_q <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         head_q       <= head_d;
         retire_cnt_q <= retire_cnt_d;
         w0_we_q <= w0_we_d;  w0_addr_q <= w0_addr_d;  w0_data_q <= w0_data_d;  w0_pid_q <= w0_pid_d;
         w1_we_q <= w1_we_d;  w1_addr_q <= w1_addr_d;  w1_data_q <= w1_data_d;  w1_pid_q <= w1_pid_d;
      end
   end

   // NOTE: slot payload is not reset; it is only ever read while its valid bit is set.
   always_ff @(posedge clk) begin
      slot_wen_q  <= slot_wen_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
   end

   assign way0_rdWriteEnable_o = w0_we_q;
   assign way0_rdAddr_o        = w0_addr_q;
   assign way0_rdData_o        = w0_data_q;
   assign way0_WBU_pID_o       = w0_pid_q;
   assign way1_rdWriteEnable_o = w1_we_q;
   assign way1_rdAddr_o        = w1_addr_q;
   assign way1_rdData_o        = w1_data_q;
   assign way1_WBU_pID_o       = w1_pid_q;
   assign retire_cnt_o         = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit: in-order commit, hazards, stalls,
// flush, reset and pID wrap, with hand-computed expected values.
module tb_wb_commit_unit;
   logic        clk;
   logic        reset;
   logic        way0_valid_i, way1_valid_i;
   logic        way0_ready_o, way1_ready_o;
   logic [1:0]  way0_pID_i, way1_pID_i;
   logic        way0_rdWen_i, way1_rdWen_i;
   logic [4:0]  way0_rdAddr_i, way1_rdAddr_i;
   logic [63:0] way0_rdData_i, way1_rdData_i;
   logic        flush_i;
   logic        way0_rdWriteEnable_o, way1_rdWriteEnable_o;
   logic [4:0]  way0_rdAddr_o, way1_rdAddr_o;
   logic [63:0] way0_rdData_o, way1_rdData_o;
   logic [1:0]  way0_WBU_pID_o, way1_WBU_pID_o;
   logic        way0_ready_i, way1_ready_i;
   logic [63:0] retire_cnt_o;

   int checks = 0;
   int errors = 0;

   wb_commit_unit #(.XLEN(64), .PID_W(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .way0_valid_i         (way0_valid_i),
      .way0_ready_o         (way0_ready_o),
      .way0_pID_i           (way0_pID_i),
      .way0_rdWen_i         (way0_rdWen_i),
      .way0_rdAddr_i        (way0_rdAddr_i),
      .way0_rdData_i        (way0_rdData_i),
      .way1_valid_i         (way1_valid_i),
      .way1_ready_o         (way1_ready_o),
      .way1_pID_i           (way1_pID_i),
      .way1_rdWen_i         (way1_rdWen_i),
      .way1_rdAddr_i        (way1_rdAddr_i),
      .way1_rdData_i        (way1_rdData_i),
      .flush_i              (flush_i),
      .way0_rdWriteEnable_o (way0_rdWriteEnable_o),
      .way0_rdAddr_o        (way0_rdAddr_o),
      .way0_rdData_o        (way0_rdData_o),
      .way0_WBU_pID_o       (way0_WBU_pID_o),
      .way1_rdWriteEnable_o (way1_rdWriteEnable_o),
      .way1_rdAddr_o        (way1_rdAddr_o),
      .way1_rdData_o        (way1_rdData_o),
      .way1_WBU_pID_o       (way1_WBU_pID_o),
      .way0_ready_i         (way0_ready_i),
      .way1_ready_i         (way1_ready_i),
      .retire_cnt_o         (retire_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_way(input string tag, input bit younger, input logic we,
                          input logic [4:0] addr, input logic [63:0] data, input logic [1:0] pid);
      if (!younger) begin
         check({tag, "_we0"},   64'(way0_rdWriteEnable_o), 64'(we));
         check({tag, "_addr0"}, 64'(way0_rdAddr_o),        64'(addr));
         check({tag, "_data0"}, way0_rdData_o,             data);
         check({tag, "_pid0"},  64'(way0_WBU_pID_o),       64'(pid));
      end else begin
         check({tag, "_we1"},   64'(way1_rdWriteEnable_o), 64'(we));
         check({tag, "_addr1"}, 64'(way1_rdAddr_o),        64'(addr));
         check({tag, "_data1"}, way1_rdData_o,             data);
         check({tag, "_pid1"},  64'(way1_WBU_pID_o),       64'(pid));
      end
   endtask

   task automatic chk_we(input string tag, input logic we0, input logic we1);
      check({tag, "_we0"}, 64'(way0_rdWriteEnable_o), 64'(we0));
      check({tag, "_we1"}, 64'(way1_rdWriteEnable_o), 64'(we1));
   endtask

   task automatic chk_cnt(input string tag, input logic [63:0] exp);
      check({tag, "_cnt"}, retire_cnt_o, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [1:0] pid, input logic wen, input logic [4:0] addr,
                        input logic [63:0] data);
      way0_valid_i  = 1'b1;
      way0_pID_i    = pid;
      way0_rdWen_i  = wen;
      way0_rdAddr_i = addr;
      way0_rdData_i = data;
   endtask

   task automatic send1(input logic [1:0] pid, input logic wen, input logic [4:0] addr,
                        input logic [63:0] data);
      way1_valid_i  = 1'b1;
      way1_pID_i    = pid;
      way1_rdWen_i  = wen;
      way1_rdAddr_i = addr;
      way1_rdData_i = data;
   endtask

   task automatic idle();
      way0_valid_i = 1'b0;
      way1_valid_i = 1'b0;
   endtask

   initial begin
      logic [1:0] p0;
      reset = 1'b1;  flush_i = 1'b0;
      way0_ready_i = 1'b1;  way1_ready_i = 1'b1;
      way0_valid_i = 1'b0;  way0_pID_i = 2'd0;  way0_rdWen_i = 1'b0;
      way0_rdAddr_i = 5'd0;  way0_rdData_i = 64'd0;
      way1_valid_i = 1'b0;  way1_pID_i = 2'd1;  way1_rdWen_i = 1'b0;
      way1_rdAddr_i = 5'd0;  way1_rdData_i = 64'd0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      chk_way("rst", 1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
      chk_way("rst", 1'b1, 1'b0, 5'd0, 64'd0, 2'd0);
      chk_cnt("rst", 64'd0);
      check("rst_rdy0", 64'(way0_ready_o), 64'd1);
      check("rst_rdy1", 64'(way1_ready_o), 64'd1);

      // Pair 00/01 accepted together, committed one edge later
      send0(2'd0, 1'b1, 5'd5, 64'hA);
      send1(2'd1, 1'b1, 5'd6, 64'hB);
      #1;
      check("t1_rdy0", 64'(way0_ready_o), 64'd1);
      check("t1_rdy1", 64'(way1_ready_o), 64'd1);
      step();
      idle();
      chk_we("t1_nobypass", 1'b0, 1'b0);
      step();
      chk_way("t1", 1'b0, 1'b1, 5'd5, 64'hA, 2'd0);
      chk_way("t1", 1'b1, 1'b1, 5'd6, 64'hB, 2'd1);
      chk_cnt("t1", 64'd2);
      step();
      chk_we("t1_drain", 1'b0, 1'b0);

      // Younger pID 11 waits for older pID 10 (head is 10 now)
      send1(2'd3, 1'b1, 5'd9, 64'h33);
      step();
      idle();
      chk_we("t2_wait_a", 1'b0, 1'b0);
      step();
      chk_we("t2_wait_b", 1'b0, 1'b0);
      chk_cnt("t2_wait", 64'd2);
      send0(2'd2, 1'b1, 5'd8, 64'h22);
      step();
      idle();
      chk_we("t2_nobypass", 1'b0, 1'b0);
      step();
      chk_way("t2", 1'b0, 1'b1, 5'd8, 64'h22, 2'd2);
      chk_way("t2", 1'b1, 1'b1, 5'd9, 64'h33, 2'd3);
      chk_cnt("t2", 64'd4);

      // Same-rd hazard: only the younger write survives (head wrapped to 00)
      send0(2'd0, 1'b1, 5'd7, 64'h1);
      send1(2'd1, 1'b1, 5'd7, 64'h2);
      step();
      idle();
      step();
      check("t3_we0", 64'(way0_rdWriteEnable_o), 64'd0);
      chk_way("t3", 1'b1, 1'b1, 5'd7, 64'h2, 2'd1);
      chk_cnt("t3", 64'd6);

      // Regfile stall for 3 cycles with pID 10 buffered
      way1_ready_i = 1'b0;
      send0(2'd2, 1'b1, 5'd10, 64'h44);
      step();
      idle();
      chk_way("t4_hold_a", 1'b1, 1'b1, 5'd7, 64'h2, 2'd1);
      chk_cnt("t4_hold_a", 64'd6);
      send0(2'd2, 1'b1, 5'd10, 64'h44);
      way1_pID_i = 2'd3;
      #1;
      check("t4_resend_rdy0", 64'(way0_ready_o), 64'd0);
      check("t4_free_rdy1", 64'(way1_ready_o), 64'd1);
      idle();
      step();
      step();
      chk_way("t4_hold_b", 1'b1, 1'b1, 5'd7, 64'h2, 2'd1);
      chk_cnt("t4_hold_b", 64'd6);
      way1_ready_i = 1'b1;
      step();
      chk_way("t4", 1'b0, 1'b1, 5'd10, 64'h44, 2'd2);
      chk_way("t4", 1'b1, 1'b0, 5'd0, 64'd0, 2'd0);
      chk_cnt("t4", 64'd7);

      // Wrap: head 11 commits 11 (rd 0, no write) and 00 together
      send1(2'd3, 1'b1, 5'd0, 64'h55);
      send0(2'd0, 1'b1, 5'd12, 64'h56);
      step();
      idle();
      step();
      chk_way("t5", 1'b0, 1'b0, 5'd0, 64'h55, 2'd3);
      chk_way("t5", 1'b1, 1'b1, 5'd12, 64'h56, 2'd0);
      chk_cnt("t5", 64'd9);
      send1(2'd1, 1'b1, 5'd13, 64'h57);
      step();
      idle();
      step();
      chk_way("t5b", 1'b0, 1'b1, 5'd13, 64'h57, 2'd1);
      chk_cnt("t5b", 64'd10);

      // Flush with slots 10 and 11 buffered behind a stall
      way0_ready_i = 1'b0;
      send0(2'd2, 1'b1, 5'd3, 64'h70);
      send1(2'd3, 1'b1, 5'd4, 64'h71);
      step();
      idle();
      check("t6_hold_we0", 64'(way0_rdWriteEnable_o), 64'd1);
      flush_i = 1'b1;
      send0(2'd0, 1'b1, 5'd14, 64'h99);
      #1;
      check("t6_flush_rdy0", 64'(way0_ready_o), 64'd0);
      step();
      flush_i = 1'b0;
      idle();
      chk_we("t6_flush", 1'b0, 1'b0);
      chk_cnt("t6_flush", 64'd10);
      way0_pID_i = 2'd2;
      way1_pID_i = 2'd3;
      #1;
      check("t6_empty_rdy0", 64'(way0_ready_o), 64'd1);
      check("t6_empty_rdy1", 64'(way1_ready_o), 64'd1);
      way0_ready_i = 1'b1;
      step();
      chk_we("t6_idle", 1'b0, 1'b0);
      chk_cnt("t6_idle", 64'd10);
      send0(2'd0, 1'b1, 5'd1, 64'h60);
      send1(2'd1, 1'b1, 5'd2, 64'h61);
      #1;
      check("t6_post_rdy0", 64'(way0_ready_o), 64'd1);
      check("t6_post_rdy1", 64'(way1_ready_o), 64'd1);
      step();
      idle();
      step();
      chk_way("t6_post", 1'b0, 1'b1, 5'd1, 64'h60, 2'd0);
      chk_way("t6_post", 1'b1, 1'b1, 5'd2, 64'h61, 2'd1);
      chk_cnt("t6_post", 64'd12);

      // Reset mid-operation drops the buffered pID 10
      way0_ready_i = 1'b0;
      send0(2'd2, 1'b1, 5'd20, 64'h77);
      step();
      idle();
      reset = 1'b1;
      way0_ready_i = 1'b1;
      step();
      reset = 1'b0;
      chk_way("t7", 1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
      chk_way("t7", 1'b1, 1'b0, 5'd0, 64'd0, 2'd0);
      chk_cnt("t7", 64'd0);
      step();
      chk_we("t7_after", 1'b0, 1'b0);

      // Six back-to-back pairs across the 11 -> 00 wrap
      for (int k = 0; k < 6; k++) begin
         p0 = 2'((2 * k) % 4);
         send0(p0, 1'b1, 5'(2 * k + 1), 64'(256 + 2 * k));
         send1(p0 + 2'd1, 1'b1, 5'(2 * k + 2), 64'(257 + 2 * k));
         #1;
         check("t8_rdy0", 64'(way0_ready_o), 64'd1);
         check("t8_rdy1", 64'(way1_ready_o), 64'd1);
         step();
         if (k > 0) begin
            chk_way("t8", 1'b0, 1'b1, 5'(2 * k - 1), 64'(256 + 2 * (k - 1)), 2'((2 * (k - 1)) % 4));
            chk_way("t8", 1'b1, 1'b1, 5'(2 * k), 64'(257 + 2 * (k - 1)), 2'((2 * (k - 1)) % 4 + 1));
            chk_cnt("t8", 64'(2 * k));
         end
      end
      idle();
      step();
      chk_way("t8_last", 1'b0, 1'b1, 5'd11, 64'd266, 2'd2);
      chk_way("t8_last", 1'b1, 1'b1, 5'd12, 64'd267, 2'd3);
      chk_cnt("t8_last", 64'd12);
      step();
      chk_we("t8_drain", 1'b0, 1'b0);
      chk_cnt("t8_drain", 64'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
